// File: rtl/expr_sig_pkg.sv
// Shared types and defaults for the expression-result signature stage.
// fold() is the reference chunk-XOR used wherever a software view of the fold is needed.
package expr_sig_pkg;

    localparam int unsigned DEF_Y_W   = 90;
    localparam int unsigned DEF_SIG_W = 32;
    localparam int unsigned DEF_CNT_W = 16;
    localparam logic [DEF_SIG_W-1:0] DEF_POLY = 32'h04C11DB7;
    localparam logic [DEF_SIG_W-1:0] DEF_SEED = 32'hFFFFFFFF;

    localparam int unsigned DEF_CHUNKS = (DEF_Y_W + DEF_SIG_W - 1) / DEF_SIG_W;
    localparam int unsigned DEF_PAD_W  = DEF_CHUNKS * DEF_SIG_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // XOR of SIG_W-bit chunks of y, top chunk zero-padded.
    function automatic logic [DEF_SIG_W-1:0] fold(input logic [DEF_Y_W-1:0] y);
        logic [DEF_PAD_W-1:0] pad;
        logic [DEF_SIG_W-1:0] acc;
        pad = DEF_PAD_W'(y);
        acc = '0;
        for (int k = 0; k < int'(DEF_CHUNKS); k++) begin
            acc = acc ^ pad[k*DEF_SIG_W +: DEF_SIG_W];
        end
        return acc;
    endfunction

endpackage

// File: rtl/expr_sig_fold.sv
// Purely combinational Y_W -> SIG_W XOR fold of the incoming result word.
module expr_sig_fold #(
    parameter int unsigned Y_W   = 90,
    parameter int unsigned SIG_W = 32
) (
    input  logic [Y_W-1:0]   i_y,
    output logic [SIG_W-1:0] o_fold
);

    localparam int unsigned CHUNKS = (Y_W + SIG_W - 1) / SIG_W;
    localparam int unsigned PAD_W  = CHUNKS * SIG_W;

    logic [PAD_W-1:0] w_pad;

    assign w_pad = PAD_W'(i_y);

    always_comb begin
        o_fold = '0;
        for (int k = 0; k < int'(CHUNKS); k++) begin
            o_fold = o_fold ^ w_pad[k*SIG_W +: SIG_W];
        end
    end

endmodule

// File: rtl/expr_result_signature.sv
// Capture stage: compresses accepted y samples into a MISR signature and
// presents it on a ready/valid port once the programmed sample count is reached.
module expr_result_signature
    import expr_sig_pkg::*;
#(
    parameter int unsigned      Y_W   = DEF_Y_W,
    parameter int unsigned      SIG_W = DEF_SIG_W,
    parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED  = DEF_SEED,
    parameter int unsigned      CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Y_W-1:0]   y,
    output logic             sig_valid,
    input  logic             sig_ready,
    output logic [SIG_W-1:0] sig,
    output logic [CNT_W-1:0] sample_cnt,
    output logic             busy
);

    state_t           r_state;
    logic [SIG_W-1:0] r_sig;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_num;
    logic             r_sig_valid;
    logic             r_busy;

    logic [SIG_W-1:0] w_fold;
    logic [SIG_W-1:0] w_sig_next;
    logic             w_last;

    expr_sig_fold #(
        .Y_W   (Y_W),
        .SIG_W (SIG_W)
    ) u_fold (
        .i_y    (y),
        .o_fold (w_fold)
    );

    // One MISR step: shift left, feed back POLY when the MSB falls out, inject the folded sample.
    assign w_sig_next = {r_sig[SIG_W-2:0], 1'b0}
                      ^ (r_sig[SIG_W-1] ? POLY : {SIG_W{1'b0}})
                      ^ w_fold;

    assign w_last   = (r_cnt == (r_num - CNT_W'(1)));
    assign in_ready = (r_state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sig       <= SEED;
            r_cnt       <= '0;
            r_num       <= '0;
            r_sig_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sig  <= SEED;
                        r_cnt  <= '0;
                        r_num  <= num_samples;
                        r_busy <= 1'b1;
                        if (num_samples == '0) begin
                            r_state     <= DONE;
                            r_sig_valid <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        r_sig <= w_sig_next;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_state     <= DONE;
                            r_sig_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // start is deliberately ignored here, even on the handshake cycle.
                    if (sig_ready) begin
                        r_state     <= IDLE;
                        r_sig_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_sig_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign sig        = r_sig;
    assign sample_cnt = r_cnt;
    assign sig_valid  = r_sig_valid;
    assign busy       = r_busy;

endmodule
